// File: rtl/wb_write_queue_if.sv
// ---------------------------------------------------------------------------
// wb_write_queue_if
// Bundle of signals between the datapath / register file and the buffered
// writeback queue.
//   request side : in_valid, in_ready, in_reg_no, in_data
//   drain side   : drain_en, reg_write, write_reg_no, write_data
//   read paths   : read_reg1/2, rf_data1/2 (from register file),
//                  read_data1/2 (forwarded results)
//   status       : count, empty, full
// Modport "slave" is the queue itself; "master" is the datapath / regfile side.
// ---------------------------------------------------------------------------
interface wb_write_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg_no;
    logic [DATA_W-1:0] in_data;
    logic              drain_en;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg_no;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport slave (
        input  in_valid, in_reg_no, in_data, drain_en,
               read_reg1, read_reg2, rf_data1, rf_data2,
        output in_ready, reg_write, write_reg_no, write_data,
               read_data1, read_data2, count, empty, full
    );

    modport master (
        output in_valid, in_reg_no, in_data, drain_en,
               read_reg1, read_reg2, rf_data1, rf_data2,
        input  in_ready, reg_write, write_reg_no, write_data,
               read_data1, read_data2, count, empty, full
    );
endinterface

// File: rtl/wb_write_queue.sv
// ---------------------------------------------------------------------------
// wb_write_queue
// Buffered writeback initiator for the register file write port. Requests are
// accepted on a valid/ready handshake into an in-order circular FIFO and are
// drained at most one per cycle (when drain_en) onto reg_write/write_reg_no/
// write_data. Both read paths are forwarded from the youngest queued entry
// with a matching register number, so reads never see stale contents.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, discards all pending entries
//   bus  : wb_write_queue_if.slave (see interface header for signal list)
// ---------------------------------------------------------------------------
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_write_queue_if.slave      bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic [ADDR_W-1:0] regno_mem [DEPTH];
    logic [DATA_W-1:0] data_mem  [DEPTH];

    logic empty, full, push, pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));
    // A full queue refuses a push even when a pop frees a slot this cycle.
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && bus.drain_en;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (push) tail_next = tail_reg + 1'b1;
        if (pop)  head_next = head_reg + 1'b1;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry storage carries no reset: validity is defined purely by the
    // pointers, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            regno_mem[tail_reg] <= bus.in_reg_no;
            data_mem[tail_reg]  <= bus.in_data;
        end
    end

    assign bus.in_ready     = !full;
    assign bus.count        = count_reg;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.reg_write    = pop;
    assign bus.write_reg_no = empty ? '0 : regno_mem[head_reg];
    assign bus.write_data   = empty ? '0 : data_mem[head_reg];

    // Slot gi is the gi-th oldest queued entry; it is live when gi < count.
    logic [PTR_W-1:0] slot_idx [DEPTH];
    logic [DEPTH-1:0] match1, match2;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic slot_valid;
            assign slot_idx[gi] = head_reg + PTR_W'(gi);
            assign slot_valid   = (CNT_W'(gi) < count_reg);
            assign match1[gi]   = slot_valid && (regno_mem[slot_idx[gi]] == bus.read_reg1);
            assign match2[gi]   = slot_valid && (regno_mem[slot_idx[gi]] == bus.read_reg2);
        end
    endgenerate

    // Walk oldest to youngest so the youngest match overrides earlier ones.
    always_comb begin
        bus.read_data1 = bus.rf_data1;
        bus.read_data2 = bus.rf_data2;
        for (int i = 0; i < DEPTH; i++) begin
            if (match1[i]) bus.read_data1 = data_mem[slot_idx[i]];
            if (match2[i]) bus.read_data2 = data_mem[slot_idx[i]];
        end
    end
endmodule
